sha256_compress_iter: RTL and testbench



---
 rtl/sha256_compress_iter.sv | 155 +++++++++++++++
 tb/tb_sha256_compress_iter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sha256_compress_iter.sv
// Iterative SHA-256 compression: one 512-bit block in, updated 256-bit chaining value out.
// ROUNDS_PER_CYCLE rounds are chained per clock; 64/ROUNDS_PER_CYCLE RUN cycles plus one feed-forward cycle.
module sha256_compress_iter #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         init,
  input  logic [511:0] block_in,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest
);

  localparam int         R  = ROUNDS_PER_CYCLE;
  localparam logic [6:0] R7 = 7'(R);

  if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K_ROM = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // One compression round on the packed working state {a,b,c,d,e,f,g,h}.
  function automatic logic [255:0] main_loop(input logic [255:0] s, input logic [31:0] k,
                                             input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + big_sigma1(e) + ((e & f) ^ (~e & g)) + k + w;
    t2 = big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, FINAL} state_t;

  state_t         state_q;
  logic           ready_q, busy_q, done_q;
  logic [6:0]     t_q;
  logic [255:0]   digest_q, digest_d;
  logic [255:0]   h_q;
  logic [255:0]   s_q, s_d;
  logic [31:0]    w_q [16];
  logic [31:0]    w_d [16];
  logic [31:0]    ext [16+R];
  logic [255:0]   chain;
  logic [5:0]     kidx;

  assign chain = init ? IV : digest_q;

  // Window holds W[t..t+15]; the R new schedule words extend it before the shift.
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = w_q[i];
    for (int k = 0; k < R; k++) begin
      ext[16+k] = small_sigma1(ext[14+k]) + ext[9+k] + small_sigma0(ext[1+k]) + ext[k];
    end
    for (int i = 0; i < 16; i++) w_d[i] = ext[i+R];

    s_d  = s_q;
    kidx = '0;
    for (int k = 0; k < R; k++) begin
      kidx = t_q[5:0] + 6'(k);
      s_d  = main_loop(s_d, K_ROM[kidx], ext[k]);
    end

    digest_d = '0;
    for (int i = 0; i < 8; i++) begin
      digest_d[255-32*i -: 32] = h_q[255-32*i -: 32] + s_q[255-32*i -: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      t_q      <= '0;
      digest_q <= IV;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            t_q     <= '0;
          end
        end
        RUN: begin
          t_q <= t_q + R7;
          if (t_q + R7 == 7'd64) state_q <= FINAL;
        end
        FINAL: begin
          digest_q <= digest_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          ready_q  <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath registers need no reset: every block reloads them on accept.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      for (int i = 0; i < 16; i++) w_q[i] <= block_in[511-32*i -: 32];
      h_q <= chain;
      s_q <= chain;
    end else if (state_q == RUN) begin
      for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
      s_q <= s_d;
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign digest = digest_q;

endmodule

// File: tb/tb_sha256_compress_iter.sv
// Directed bench: four engines (R = 1, 2, 4, 8) checked against known SHA-256 digests.
module tb_sha256_compress_iter;

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [511:0] B_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B_TWO1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] B_TWO2 = {480'h0, 32'h000001c0};

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   start_v, init_v, ready_v, busy_v, done_v;
  logic [511:0] blk [4];
  logic [255:0] dig [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha256_compress_iter #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_v[g]),
      .init     (init_v[g]),
      .block_in (blk[g]),
      .ready    (ready_v[g]),
      .busy     (busy_v[g]),
      .done     (done_v[g]),
      .digest   (dig[g])
    );
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic accept(input int r, input logic ini, input logic [511:0] b);
    start_v[r] = 1'b1;
    init_v[r]  = ini;
    blk[r]     = b;
    @(posedge clk); #1;
    start_v[r] = 1'b0;
    blk[r]     = {16{$urandom()}};
  endtask

  // Cycles from the accept edge until done is seen; -1 if the bound expires.
  task automatic wait_done(input int r, input bit toggle, input bit chk_stable, output int lat);
    logic [255:0] prev;
    prev = dig[r];
    lat  = -1;
    for (int c = 1; c <= 200; c++) begin
      if (toggle) begin
        start_v[r] = ~start_v[r];
        init_v[r]  = ~init_v[r];
        blk[r]     = ~blk[r];
      end
      @(posedge clk); #1;
      if (done_v[r]) begin
        lat = c;
        break;
      end
      if (chk_stable) check("digest_stable_r8", dig[r], prev);
    end
    start_v[r] = 1'b0;
  endtask

  initial begin
    int lat;
    int ndone;
    rst     = 1'b1;
    start_v = '0;
    init_v  = '0;
    for (int i = 0; i < 4; i++) blk[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 256'(ready_v), 256'(4'hf));
    check("reset_busy", 256'(busy_v), 256'(0));
    check("reset_done", 256'(done_v), 256'(0));
    check("reset_digest_r1", dig[0], IV);
    check("reset_digest_r8", dig[3], IV);
    rst = 1'b0;
    @(posedge clk); #1;

    accept(0, 1'b1, B_ABC);
    check("abc_r1_busy", 256'(busy_v[0]), 256'(1));
    check("abc_r1_ready", 256'(ready_v[0]), 256'(0));
    check("abc_r1_mid_digest", dig[0], IV);
    wait_done(0, 1'b0, 1'b0, lat);
    check("abc_r1_latency", 256'(lat), 256'(65));
    check("abc_r1_digest", dig[0], D_ABC);
    check("abc_r1_done_ready", 256'(ready_v[0]), 256'(1));
    check("abc_r1_done_busy", 256'(busy_v[0]), 256'(0));
    @(posedge clk); #1;
    check("abc_r1_done_pulse", 256'(done_v[0]), 256'(0));

    accept(2, 1'b1, B_EMPTY);
    wait_done(2, 1'b0, 1'b0, lat);
    check("empty_r4_latency", 256'(lat), 256'(17));
    check("empty_r4_digest", dig[2], D_EMPTY);

    accept(1, 1'b1, B_TWO1);
    wait_done(1, 1'b0, 1'b0, lat);
    check("two_r2_blk1_latency", 256'(lat), 256'(33));
    accept(1, 1'b0, B_TWO2);
    check("two_r2_b2b_busy", 256'(busy_v[1]), 256'(1));
    wait_done(1, 1'b0, 1'b0, lat);
    check("two_r2_blk2_latency", 256'(lat), 256'(33));
    check("two_r2_digest", dig[1], D_TWO);

    accept(0, 1'b1, B_ABC);
    wait_done(0, 1'b1, 1'b0, lat);
    check("busy_start_latency", 256'(lat), 256'(65));
    check("busy_start_digest", dig[0], D_ABC);
    ndone = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (done_v[0]) ndone++;
    end
    check("busy_start_no_restart", 256'(ndone), 256'(0));
    check("busy_start_idle", 256'(busy_v[0]), 256'(0));

    accept(0, 1'b1, B_ABC);
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", 256'(ready_v[0]), 256'(1));
    check("abort_busy", 256'(busy_v[0]), 256'(0));
    check("abort_done", 256'(done_v[0]), 256'(0));
    check("abort_digest", dig[0], IV);
    accept(0, 1'b1, B_ABC);
    wait_done(0, 1'b0, 1'b0, lat);
    check("rerun_latency", 256'(lat), 256'(65));
    check("rerun_digest", dig[0], D_ABC);

    accept(3, 1'b1, B_ABC);
    wait_done(3, 1'b0, 1'b1, lat);
    check("abc_r8_latency", 256'(lat), 256'(9));
    check("abc_r8_digest", dig[3], D_ABC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
